// File: rtl/spi_pkg.sv
// Shared constants for the SPI register target: byte framing, synchroniser
// depth and the default chip-ID address/value pairs.
package spi_pkg;

    localparam int BYTE_W     = 8;
    localparam int SYNC_DEPTH = 2;
    localparam int BIT_CNT_W  = $clog2(BYTE_W);

    // Bit counter value reached when the last bit of a byte is handled.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

    typedef logic [BYTE_W-1:0] spi_byte_t;

    localparam spi_byte_t DEF_CHIP_ID_1_ADDRESS = 8'hDB;
    localparam spi_byte_t DEF_CHIP_ID_1_VALUE   = 8'h81;
    localparam spi_byte_t DEF_CHIP_ID_2_ADDRESS = 8'hF4;
    localparam spi_byte_t DEF_CHIP_ID_2_VALUE   = 8'h27;

endpackage

// File: rtl/spi_register.sv
// Read-only register: answers with a fixed byte while the current opcode
// addresses it. Outputs are registered, so the answer trails the opcode by
// one cycle.
module spi_register
    import spi_pkg::*;
#(
    parameter spi_byte_t REGISTER_ADDRESS = DEF_CHIP_ID_1_ADDRESS,
    parameter spi_byte_t REGISTER_VALUE   = DEF_CHIP_ID_1_VALUE
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic [BYTE_W-1:0] opcode_in,
    input  logic              opcode_valid_in,
    output logic [BYTE_W-1:0] response_out,
    output logic              response_valid_out
);

    logic [BYTE_W-1:0] r_response;
    logic              r_response_valid;

    // Present the register value only while our address is the live opcode.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_response       <= '0;
            r_response_valid <= 1'b0;
        end else if (opcode_valid_in && (opcode_in == REGISTER_ADDRESS)) begin
            r_response       <= REGISTER_VALUE;
            r_response_valid <= 1'b1;
        end else begin
            r_response       <= '0;
            r_response_valid <= 1'b0;
        end
    end

    assign response_out       = r_response;
    assign response_valid_out = r_response_valid;

endmodule

// File: rtl/spi_register_target.sv
// SPI mode-0 target front-end. Deserialises an opcode byte followed by
// operand bytes and returns one response byte per operand byte on MISO.
//
// Valid semantics (no back-pressure on this side):
//   opcode_valid_out  - level, high from opcode completion until select is
//                       seen high; opcode_out is stable while it is high.
//   operand_valid_out - exactly one cycle per completed operand byte;
//                       operand_out holds that byte until the next one.
//   response_valid_in - level, sampled continuously; qualifies response_in
//                       for the current opcode.
module spi_register_target
    import spi_pkg::*;
#(
    parameter spi_byte_t CHIP_ID_1_ADDRESS = DEF_CHIP_ID_1_ADDRESS,
    parameter spi_byte_t CHIP_ID_1_VALUE   = DEF_CHIP_ID_1_VALUE,
    parameter spi_byte_t CHIP_ID_2_ADDRESS = DEF_CHIP_ID_2_ADDRESS,
    parameter spi_byte_t CHIP_ID_2_VALUE   = DEF_CHIP_ID_2_VALUE
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              spi_select_in,
    input  logic              spi_clock_in,
    input  logic              spi_data_in,
    output logic              spi_data_out,
    output logic [BYTE_W-1:0] opcode_out,
    output logic              opcode_valid_out,
    output logic [BYTE_W-1:0] operand_out,
    output logic              operand_valid_out,
    input  logic [BYTE_W-1:0] response_in,
    input  logic              response_valid_in
);

    // Synchronisers and SCLK edge detection.
    logic [SYNC_DEPTH-1:0] r_sel_sync;
    logic [SYNC_DEPTH-1:0] r_sclk_sync;
    logic [SYNC_DEPTH-1:0] r_mosi_sync;
    logic                  r_sclk_prev;
    logic                  w_sel_high;
    logic                  w_sclk;
    logic                  w_mosi;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;

    // Framing state. r_armed stays low after reset until select has been
    // seen high, so a transaction observed only in part is never decoded.
    logic                  r_armed;
    logic                  r_past_opcode;
    logic [BIT_CNT_W-1:0]  r_rise_cnt;
    logic [BIT_CNT_W-1:0]  r_fall_cnt;
    // Only the first seven bits need storing; the eighth arrives live.
    logic [BYTE_W-2:0]     r_shift_in;
    // Bit 7 of a response goes straight to MISO, the rest wait here.
    logic [BYTE_W-2:0]     r_shift_out;
    logic [BYTE_W-1:0]     w_byte_next;

    logic [BYTE_W-1:0]     r_opcode;
    logic                  r_opcode_valid;
    logic [BYTE_W-1:0]     r_operand;
    logic                  r_operand_valid;
    logic                  r_miso;

    // Response sources.
    logic [BYTE_W-1:0]     w_id1_resp;
    logic                  w_id1_valid;
    logic [BYTE_W-1:0]     w_id2_resp;
    logic                  w_id2_valid;
    logic [BYTE_W-1:0]     w_resp;

    // Bring the asynchronous SPI pins into the clock_in domain.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_sel_sync  <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sel_sync  <= {r_sel_sync[SYNC_DEPTH-2:0], spi_select_in};
            r_sclk_sync <= {r_sclk_sync[SYNC_DEPTH-2:0], spi_clock_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_DEPTH-2:0], spi_data_in};
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_sel_high  = r_sel_sync[SYNC_DEPTH-1];
    assign w_sclk      = r_sclk_sync[SYNC_DEPTH-1];
    assign w_mosi      = r_mosi_sync[SYNC_DEPTH-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_byte_next = {r_shift_in, w_mosi};

    // Shift MOSI in on rising edges, MISO out on falling edges, frame bytes.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_armed         <= 1'b0;
            r_past_opcode   <= 1'b0;
            r_rise_cnt      <= '0;
            r_fall_cnt      <= '0;
            r_shift_in      <= '0;
            r_shift_out     <= '0;
            r_opcode        <= '0;
            r_opcode_valid  <= 1'b0;
            r_operand       <= '0;
            r_operand_valid <= 1'b0;
            r_miso          <= 1'b0;
        end else if (w_sel_high) begin
            // Idle: a byte finishing in this same cycle is dropped too.
            r_armed         <= 1'b1;
            r_past_opcode   <= 1'b0;
            r_rise_cnt      <= '0;
            r_fall_cnt      <= '0;
            r_shift_in      <= '0;
            r_shift_out     <= '0;
            r_opcode_valid  <= 1'b0;
            r_operand_valid <= 1'b0;
            r_miso          <= 1'b0;
        end else if (!r_armed) begin
            r_operand_valid <= 1'b0;
        end else begin
            r_operand_valid <= 1'b0;
            if (w_sclk_rise) begin
                r_shift_in <= w_byte_next[BYTE_W-2:0];
                r_rise_cnt <= r_rise_cnt + 1'b1;
                if (r_rise_cnt == LAST_BIT) begin
                    if (!r_past_opcode) begin
                        r_opcode       <= w_byte_next;
                        r_opcode_valid <= 1'b1;
                        r_past_opcode  <= 1'b1;
                    end else begin
                        r_operand       <= w_byte_next;
                        r_operand_valid <= 1'b1;
                    end
                end
            end
            if (w_sclk_fall) begin
                r_fall_cnt <= r_fall_cnt + 1'b1;
                if (r_fall_cnt == LAST_BIT) begin
                    // Byte boundary: load the next response byte.
                    r_miso      <= w_resp[BYTE_W-1];
                    r_shift_out <= w_resp[BYTE_W-2:0];
                end else begin
                    r_miso      <= r_shift_out[BYTE_W-2];
                    r_shift_out <= {r_shift_out[BYTE_W-3:0], 1'b0};
                end
            end
        end
    end

    spi_register #(
        .REGISTER_ADDRESS (CHIP_ID_1_ADDRESS),
        .REGISTER_VALUE   (CHIP_ID_1_VALUE)
    ) u_chip_id_1 (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .opcode_in          (r_opcode),
        .opcode_valid_in    (r_opcode_valid),
        .response_out       (w_id1_resp),
        .response_valid_out (w_id1_valid)
    );

    spi_register #(
        .REGISTER_ADDRESS (CHIP_ID_2_ADDRESS),
        .REGISTER_VALUE   (CHIP_ID_2_VALUE)
    ) u_chip_id_2 (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .opcode_in          (r_opcode),
        .opcode_valid_in    (r_opcode_valid),
        .response_out       (w_id2_resp),
        .response_valid_out (w_id2_valid)
    );

    // Pick the response byte: chip ID 1, chip ID 2, external, else zero.
    always_comb begin
        w_resp = '0;
        if (w_id1_valid) begin
            w_resp = w_id1_resp;
        end else if (w_id2_valid) begin
            w_resp = w_id2_resp;
        end else if (response_valid_in) begin
            w_resp = response_in;
        end
    end

    assign spi_data_out      = r_miso;
    assign opcode_out        = r_opcode;
    assign opcode_valid_out  = r_opcode_valid;
    assign operand_out       = r_operand;
    assign operand_valid_out = r_operand_valid;

endmodule

// File: tb/tb_spi_register_target.sv
// Bench for spi_register_target: an SPI mode-0 master task, a monitor with
// expected queues for strobes, and a byte-level response model.
module tb_spi_register_target;

    logic       clock_in;
    logic       reset_in;
    logic       spi_select_in;
    logic       spi_clock_in;
    logic       spi_data_in;
    logic       spi_data_out;
    logic [7:0] opcode_out;
    logic       opcode_valid_out;
    logic [7:0] operand_out;
    logic       operand_valid_out;
    logic [7:0] response_in;
    logic       response_valid_in;

    spi_register_target dut (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .spi_select_in     (spi_select_in),
        .spi_clock_in      (spi_clock_in),
        .spi_data_in       (spi_data_in),
        .spi_data_out      (spi_data_out),
        .opcode_out        (opcode_out),
        .opcode_valid_out  (opcode_valid_out),
        .operand_out       (operand_out),
        .operand_valid_out (operand_valid_out),
        .response_in       (response_in),
        .response_valid_in (response_valid_in)
    );

    // ---------------- clock / reset ----------------
    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] tx_buf [8];
    logic [7:0] exp_q [$];
    int         exp_cyc_q [$];
    int         exp_op_cyc = -1;
    logic [7:0] exp_opcode = '0;
    logic       prev_opv = 1'b0;
    int         op_width = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    // Response a byte >= 1 should carry, straight from the priority rules.
    function automatic logic [7:0] model_resp(input logic [7:0] op);
        if (op == 8'hDB)             return 8'h81;
        else if (op == 8'hF4)        return 8'h27;
        else if (response_valid_in)  return response_in;
        else                         return 8'h00;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock_in) begin
        if (opcode_valid_out && !prev_opv) begin
            check_val("opcode_latency", cyc, exp_op_cyc);
            check_val("opcode_value", opcode_out, exp_opcode);
            exp_op_cyc = -1;
        end
        prev_opv = opcode_valid_out;
        if (operand_valid_out) begin
            op_width++;
            if (op_width == 1) begin
                if (exp_q.size() == 0) begin
                    check_val("operand_queue_depth", exp_q.size(), 1);
                end else begin
                    check_val("operand_value", operand_out, exp_q.pop_front());
                    check_val("operand_latency", cyc, exp_cyc_q.pop_front());
                end
            end
        end else begin
            if (op_width != 0) check_val("operand_width", op_width, 1);
            op_width = 0;
        end
    end

    // ---------------- driver ----------------
    // Clocks n_bits of tx_buf out MSB first. A reset pulse is inserted before
    // bit reset_at_bit (use -1 for none); afterwards nothing is expected.
    task automatic spi_txn(input int n_bits, input int half, input int reset_at_bit);
        logic [7:0] rx [8];
        logic       dead;
        logic       op_done;
        dead    = 1'b0;
        op_done = 1'b0;
        for (int k = 0; k < 8; k++) rx[k] = '0;
        spi_select_in = 1'b0;
        wait_clks(5);
        for (int j = 0; j < n_bits; j++) begin
            if (j == reset_at_bit) begin
                reset_in = 1'b1;
                wait_clks(1);
                check_val("reset_opcode_valid", opcode_valid_out, 0);
                check_val("reset_opcode", opcode_out, 0);
                check_val("reset_operand_valid", operand_valid_out, 0);
                check_val("reset_operand", operand_out, 0);
                check_val("reset_miso", spi_data_out, 0);
                reset_in = 1'b0;
                dead     = 1'b1;
                op_done  = 1'b0;
            end
            spi_data_in = tx_buf[j/8][7-(j%8)];
            wait_clks(half);
            spi_clock_in = 1'b1;
            rx[j/8][7-(j%8)] = spi_data_out;
            if (dead) check_val("miso_after_reset", spi_data_out, 0);
            if (!dead && (j % 8 == 7)) begin
                if (j == 7) begin
                    exp_opcode = tx_buf[0];
                    exp_op_cyc = cyc + 3;
                    op_done    = 1'b1;
                end else begin
                    exp_q.push_back(tx_buf[j/8]);
                    exp_cyc_q.push_back(cyc + 3);
                end
            end
            wait_clks(half);
            spi_clock_in = 1'b0;
        end
        wait_clks(half);
        if (!dead) begin
            for (int k = 0; k < n_bits / 8; k++)
                check_val($sformatf("miso_byte%0d", k), rx[k], (k == 0) ? 8'h00 : model_resp(tx_buf[0]));
            if (op_done) check_val("opcode_out_held", opcode_out, tx_buf[0]);
        end
        check_val("opcode_valid_held", opcode_valid_out, op_done);
        check_val("operand_pending", exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        exp_op_cyc = -1;
        // Deselect: opcode_valid and MISO drop exactly three cycles later.
        spi_select_in = 1'b1;
        wait_clks(2);
        check_val("desel_opv_still", opcode_valid_out, op_done);
        wait_clks(1);
        check_val("desel_opv_low", opcode_valid_out, 0);
        check_val("desel_miso_low", spi_data_out, 0);
        wait_clks(4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_in          = 1'b1;
        spi_select_in     = 1'b1;
        spi_clock_in      = 1'b0;
        spi_data_in       = 1'b0;
        response_in       = 8'h00;
        response_valid_in = 1'b0;
        for (int k = 0; k < 8; k++) tx_buf[k] = '0;
        wait_clks(5);
        reset_in = 1'b0;
        wait_clks(5);
        check_val("idle_opcode_valid", opcode_valid_out, 0);
        check_val("idle_opcode", opcode_out, 0);
        check_val("idle_operand_valid", operand_valid_out, 0);
        check_val("idle_operand", operand_out, 0);
        check_val("idle_miso", spi_data_out, 0);

        // Chip ID 1.
        tx_buf[0] = 8'hDB; tx_buf[1] = 8'hFF;
        spi_txn(16, 5, -1);

        // Chip ID 2 with three operands.
        tx_buf[0] = 8'hF4; tx_buf[1] = 8'h12; tx_buf[2] = 8'h43; tx_buf[3] = 8'h65;
        spi_txn(32, 5, -1);

        // Unknown opcode, then the same with an external response.
        tx_buf[0] = 8'h55; tx_buf[1] = 8'h3C;
        spi_txn(16, 4, -1);
        response_in = 8'hA5; response_valid_in = 1'b1;
        spi_txn(16, 4, -1);

        // Chip ID wins over a valid external response.
        tx_buf[0] = 8'hDB;
        spi_txn(16, 4, -1);
        response_valid_in = 1'b0;

        // Partial byte is discarded, next transaction is clean.
        tx_buf[0] = 8'hFF;
        spi_txn(5, 5, -1);
        tx_buf[0] = 8'hDB; tx_buf[1] = 8'h9E;
        spi_txn(16, 5, -1);

        // Reset in the middle of byte 1; the tail must stay silent.
        tx_buf[0] = 8'hDB; tx_buf[1] = 8'hC3; tx_buf[2] = 8'h5A;
        spi_txn(24, 5, 11);
        tx_buf[0] = 8'hF4; tx_buf[1] = 8'h00;
        spi_txn(16, 5, -1);

        // Randomised transactions.
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0:       tx_buf[0] = 8'hDB;
                1:       tx_buf[0] = 8'hF4;
                default: tx_buf[0] = 8'($urandom_range(0, 255));
            endcase
            for (int k = 1; k < 8; k++) tx_buf[k] = 8'($urandom_range(0, 255));
            response_in       = 8'($urandom_range(0, 255));
            response_valid_in = 1'($urandom_range(0, 1));
            spi_txn(8 * $urandom_range(1, 5), $urandom_range(4, 7), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_register_target.md
# spi_register_target

SPI target front-end for the FPGA's host link. It deserialises SPI mode-0 transactions into an opcode byte followed by operand bytes, and serialises a response byte back on MISO. It contains two parameterised read-only chip-ID registers and one external response port for user logic. It sits between the MCU SPI pins and the FPGA's internal register and command blocks.

## Interface
Parameters:
- CHIP_ID_1_ADDRESS, 'hDB: opcode that selects chip-ID register 1.
- CHIP_ID_1_VALUE, 'h81: byte returned by register 1.
- CHIP_ID_2_ADDRESS, 'hF4: opcode that selects chip-ID register 2.
- CHIP_ID_2_VALUE, 'h27: byte returned by register 2.

Ports:
- clock_in, in, 1: system clock. This is the only clock.
- reset_in, in, 1: synchronous, active-high reset.
- spi_select_in, in, 1: chip select, active-low, asynchronous.
- spi_clock_in, in, 1: SCLK, idles low, asynchronous.
- spi_data_in, in, 1: MOSI.
- spi_data_out, out, 1: MISO.
- opcode_out, out, 8: first byte of the current transaction.
- opcode_valid_out, out, 1: high while opcode_out is valid for the current transaction.
- operand_out, out, 8: most recent operand byte.
- operand_valid_out, out, 1: one-cycle pulse per completed operand byte.
- response_in, in, 8: response byte from external logic.
- response_valid_in, in, 1: response_in is valid for the current opcode.

## Operation
- spi_select_in, spi_clock_in and spi_data_in each pass through a 2-FF synchroniser. SCLK edges are detected on the synchronised signal.
- Mode 0:
  - MOSI is sampled on each SCLK rising edge, MSB first.
  - MISO changes on each SCLK falling edge.
- Select high (idle):
  - Bit counter and byte index are cleared.
  - opcode_valid_out = 0 and spi_data_out = 0.
  - Any partial byte is discarded and produces no valid strobe.
- Byte 0 completes on its 8th rising edge:
  - opcode_out <= byte.
  - opcode_valid_out = 1, held until select deasserts.
- Each later byte completes on its 8th rising edge:
  - operand_out <= byte.
  - operand_valid_out pulses for one cycle.
- Response mux, in priority order:
  1. Chip-ID register 1 valid.
  2. Chip-ID register 2 valid.
  3. response_valid_in.
  4. Otherwise 8'h00.
- MISO framing:
  - MISO is 0 throughout byte 0.
  - On the 8th falling edge of every byte (the byte boundary), the output shift register reloads from the mux and drives its bit 7.
  - Each subsequent falling edge shifts out the next bit.
  - Result: bytes 1, 2, 3… each return the currently selected response.
- spi_register (each instance):
  - When opcode_valid_in is high and opcode_in == REGISTER_ADDRESS: response_out <= REGISTER_VALUE and response_valid_out <= 1.
  - Otherwise both outputs are 0.
  - Both outputs are registered.
- Reset, held or applied mid-transaction:
  - All outputs go to 0 on the next edge: opcode_out, operand_out, both valids, spi_data_out and the register responses.
  - After reset releases, the block ignores SPI activity until select has been seen high.
  - Result: a partially observed transaction never produces strobes.

## Timing
- Requirement: SCLK half-period ≥ 4 clock_in cycles. Select setup to the first SCLK edge ≥ 4 cycles.
- Opcode latency: opcode_valid_out rises 3 cycles after the 8th SCLK rising edge of byte 0 (2-FF synchroniser plus edge detect).
- Register response latency: 1 cycle after opcode_valid_out. It is therefore stable before the byte-0 boundary falling edge.
- operand_valid_out: 3 cycles after the 8th rising edge of each operand byte, width exactly 1 cycle.
- Select deassert:
  - opcode_valid_out and spi_data_out drop 3 cycles after select rises.
  - Register responses drop 1 cycle later.
- Coincident events:
  - A byte completing in the same cycle that select is seen high is discarded.
  - Reset has priority over everything.

## Structure
- Package spi_pkg holds the byte width (8), synchroniser depth (2) and default chip-ID address/value constants.
- The top level contains the SPI shift/framing logic and the response mux.
- Sub-module spi_register (ports clock_in, reset_in, opcode_in, opcode_valid_in, response_out, response_valid_out) is instantiated twice for the chip IDs.

## Test plan
- After reset: select high, SCLK idle → all outputs 0, MISO 0.
- Chip ID 1: select low, send 0xDB then 0xFF → opcode_out 0xDB with opcode_valid_out high; operand_out 0xFF with one pulse; MISO during byte 1 = 0x81.
- Chip ID 2 with extra operands: send 0xF4, 0x12, 0x43, 0x65 → three operand pulses carrying 0x12, 0x43, 0x65; MISO returns 0x27 in bytes 1–3.
- Unknown opcode 0x55 → MISO 0x00. Repeat with response_in = 0xA5 and response_valid_in = 1 → MISO 0xA5.
- Partial byte: 5 bits, then select high → no opcode_valid_out. Next full 0xDB transaction returns 0x81.
- Reset asserted mid-byte 1 → all outputs 0 within 1 cycle. Continued SCLK produces no strobes until select toggles high then low.
